// File: rtl/rv32_pkg.sv
// RV32I shared decode definitions: base opcodes, instruction format codes,
// the canonical NOP word and the opcode-to-format mapping.
package rv32_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   // addi x0,x0,0
   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [2:0] opc_to_fmt(input logic [6:0] opc);
      logic [2:0] f;
      case (opc)
         OPC_OP:                         f = FMT_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = FMT_I;
         OPC_STORE:                      f = FMT_S;
         OPC_BRANCH:                     f = FMT_B;
         OPC_LUI, OPC_AUIPC:             f = FMT_U;
         OPC_JAL:                        f = FMT_J;
         default:                        f = FMT_ILL;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the sign-extended immediate of an RV32I word
// for a given format. Purely combinational so the branch unit can reuse it.
module imm_gen
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     insn,
   input  logic [2:0]      fmt,
   output logic [XLEN-1:0] imm
);

   // The opcode bits carry no immediate information.
   logic w_unused_opc;
   assign w_unused_opc = ^insn[6:0];

   // Select and sign-extend the immediate fields from insn[31].
   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I: imm = XLEN'($signed(insn[31:20]));
         FMT_S: imm = XLEN'($signed({insn[31:25], insn[11:7]}));
         FMT_B: imm = XLEN'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
         FMT_U: imm = XLEN'($signed({insn[31:12], 12'b0}));
         FMT_J: imm = XLEN'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline stage: one-entry instruction/PC register behind a
// valid/ready handshake, with combinational decode of the held word.
module decode_stage
   import rv32_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] NOP_INSN = NOP
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_insn,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      a1,
   output logic [4:0]      a2,
   output logic [4:0]      rd,
   output logic            reg_we,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic [2:0]      funct3,
   output logic            funct7_5,
   output logic [XLEN-1:0] out_pc,
   output logic            illegal
);

   logic            r_valid;
   logic [31:0]     r_insn;
   logic [XLEN-1:0] r_pc;

   logic            w_in_ready;
   logic            w_capture;
   logic [2:0]      w_fmt;
   logic [4:0]      w_rd;

   // in_ready depends only on registered state and out_ready, never on in_valid.
   assign w_in_ready = !r_valid || out_ready;
   assign w_capture  = in_valid && w_in_ready;

   // Pipeline register: flush beats capture, capture beats drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_insn  <= NOP_INSN;
         r_pc    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_insn  <= NOP_INSN;
      end else if (w_capture) begin
         r_valid <= 1'b1;
         r_insn  <= in_insn;
         r_pc    <= in_pc;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign w_fmt = opc_to_fmt(r_insn[6:0]);
   assign w_rd  = r_insn[11:7];

   // Register addresses are zeroed for formats that do not read them so the
   // hazard logic downstream never sees a false dependency.
   always_comb begin
      a1 = r_insn[19:15];
      a2 = r_insn[24:20];
      if (w_fmt == FMT_U || w_fmt == FMT_J || w_fmt == FMT_ILL)
         a1 = 5'd0;
      if (!(w_fmt == FMT_R || w_fmt == FMT_S || w_fmt == FMT_B))
         a2 = 5'd0;
   end

   // Writeback enable: only formats with a destination, and never for x0.
   always_comb begin
      reg_we = 1'b0;
      if (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_U || w_fmt == FMT_J)
         reg_we = (w_rd != 5'd0);
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .insn (r_insn),
      .fmt  (w_fmt),
      .imm  (imm)
   );

   assign in_ready  = w_in_ready;
   assign out_valid = r_valid;
   assign rd        = w_rd;
   assign fmt       = w_fmt;
   assign funct3    = r_insn[14:12];
   assign funct7_5  = r_insn[30];
   assign out_pc    = r_pc;
   assign illegal   = (w_fmt == FMT_ILL);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, per-format decode, stall,
// back-to-back transfer, drain, flush and asynchronous reset.
module tb_decode_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [4:0]  rd;
   logic        reg_we;
   logic [31:0] imm;
   logic [2:0]  fmt;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [31:0] out_pc;
   logic        illegal;

   int n_checks;
   int n_errors;

   decode_stage #(.XLEN(32), .NOP_INSN(32'h0000_0013)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_insn   (in_insn),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a1        (a1),
      .a2        (a2),
      .rd        (rd),
      .reg_we    (reg_we),
      .imm       (imm),
      .fmt       (fmt),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .out_pc    (out_pc),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction with out_ready=1 and let it be captured.
   task automatic send(input logic [31:0] insn, input logic [31:0] pc);
      in_valid  = 1'b1;
      in_insn   = insn;
      in_pc     = pc;
      out_ready = 1'b1;
      step();
   endtask

   task automatic chk_dec(input string tag, input logic [4:0] e_a1, input logic [4:0] e_a2,
                          input logic [4:0] e_rd, input logic e_we, input logic [31:0] e_imm,
                          input logic [2:0] e_fmt, input logic e_ill);
      chk({tag, ".a1"},      32'(a1),      32'(e_a1));
      chk({tag, ".a2"},      32'(a2),      32'(e_a2));
      chk({tag, ".rd"},      32'(rd),      32'(e_rd));
      chk({tag, ".reg_we"},  32'(reg_we),  32'(e_we));
      chk({tag, ".imm"},     imm,          e_imm);
      chk({tag, ".fmt"},     32'(fmt),     32'(e_fmt));
      chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_insn   = 32'hFFF0_8293;
      in_pc     = 32'h0000_0100;
      flush     = 1'b0;
      out_ready = 1'b1;

      // Reset held with a valid instruction at the input
      repeat (3) step();
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_pc", out_pc, 32'd0);
      chk_dec("rst", 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd1, 1'b0);

      rst = 1'b1;
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      step();
      chk("addi.out_valid", 32'(out_valid), 32'd1);
      chk("addi.out_pc", out_pc, 32'h0000_0100);
      chk_dec("addi", 5'd1, 5'd0, 5'd5, 1'b1, 32'hFFFF_FFFF, 3'd1, 1'b0);

      send(32'h0021_A423, 32'h0000_0104);  // sw x2,8(x3)
      chk_dec("sw", 5'd3, 5'd2, 5'd8, 1'b0, 32'd8, 3'd2, 1'b0);
      chk("sw.funct3", 32'(funct3), 32'd2);

      send(32'hFE20_8EE3, 32'h0000_0108);  // beq x1,x2,-4
      chk_dec("beq", 5'd1, 5'd2, 5'd29, 1'b0, 32'hFFFF_FFFC, 3'd3, 1'b0);

      send(32'h1234_53B7, 32'h0000_010C);  // lui x7,0x12345
      chk_dec("lui", 5'd0, 5'd0, 5'd7, 1'b1, 32'h1234_5000, 3'd4, 1'b0);

      send(32'h0000_007F, 32'h0000_0110);  // unsupported opcode
      chk_dec("ill", 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd7, 1'b0 | 1'b1);

      send(32'h0080_00EF, 32'h0000_0114);  // jal x1,8
      chk_dec("jal", 5'd0, 5'd0, 5'd1, 1'b1, 32'd8, 3'd5, 1'b0);

      send(32'h0020_81B3, 32'h0000_0118);  // add x3,x1,x2
      chk_dec("add", 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 3'd0, 1'b0);
      chk("add.funct7_5", 32'(funct7_5), 32'd0);

      send(32'h0000_0013, 32'h0000_011C);  // nop: rd=x0 so no writeback
      chk_dec("nop", 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd1, 1'b0);

      send(32'h1234_53B7, 32'h0000_0120);  // lui x7 held during stall
      // Stall: downstream not ready, next instruction waiting
      out_ready = 1'b0;
      in_insn   = 32'h4020_81B3;           // sub x3,x1,x2
      in_pc     = 32'h0000_0124;
      #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall%0d.out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'd0);
         chk($sformatf("stall%0d.out_pc", i), out_pc, 32'h0000_0120);
         chk_dec($sformatf("stall%0d", i), 5'd0, 5'd0, 5'd7, 1'b1, 32'h1234_5000, 3'd4, 1'b0);
      end

      // Release: back-to-back transfer, no bubble
      out_ready = 1'b1;
      #1;
      chk("b2b.in_ready", 32'(in_ready), 32'd1);
      step();
      chk("b2b.out_valid", 32'(out_valid), 32'd1);
      chk("b2b.out_pc", out_pc, 32'h0000_0124);
      chk("b2b.funct7_5", 32'(funct7_5), 32'd1);
      chk_dec("b2b", 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 3'd0, 1'b0);

      // Drain with nothing incoming
      in_valid = 1'b0;
      step();
      chk("drain.out_valid", 32'(out_valid), 32'd0);
      step();
      chk("drain2.out_valid", 32'(out_valid), 32'd0);

      // Flush beats a simultaneous capture
      send(32'hFFF0_8293, 32'h0000_0200);
      chk("preflush.out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_insn  = 32'h1234_53B7;
      in_pc    = 32'h0000_0204;
      flush    = 1'b1;
      #1;
      chk("flush.in_ready", 32'(in_ready), 32'd1);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush.out_valid", 32'(out_valid), 32'd0);
      chk_dec("flush", 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd1, 1'b0);
      step();
      chk("postflush.out_valid", 32'(out_valid), 32'd0);
      chk("postflush.rd", 32'(rd), 32'd0);

      // Asynchronous reset between clock edges
      send(32'h0021_A423, 32'h0000_0300);
      chk("prerst.out_valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst.out_valid", 32'(out_valid), 32'd0);
      chk("arst.out_pc", out_pc, 32'd0);
      chk("arst.a1", 32'(a1), 32'd0);
      rst = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
